dp_decode_stage: RTL and testbench

- Registered, handshaked instruction-decode pipeline stage for the datapath. Sits between fetch and register-read/execute.
- Decodes each accepted instruction word into a control bundle and holds it in one output register.
- Adds EXT-prefix fusion: a prefix word supplies upper immediate bits that are merged into the next instruction's immediates.
- Supports a flush from the PC-write/redirect path.

---
 rtl/dp_pkg.sv | 34 +++
 rtl/dp_decode_core.sv | 95 +++++++++
 rtl/dp_decode_stage.sv | 115 +++++++++++
 tb/tb_dp_decode_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared types and constants for the datapath decode stage.
// Control bundle layout, class opcodes and prefix state encoding.
package dp_pkg;

    localparam int DP_W = 16;

    localparam logic [2:0] OPC_NONE  = 3'b000;
    localparam logic [2:0] OPC_CMP   = 3'b110;
    localparam logic [2:0] OPC_SHIFT = 3'b111;
    localparam logic [7:0] PCW_OPC   = 8'hCE;

    typedef enum logic {
        EXT_NONE = 1'b0,
        EXT_PEND = 1'b1
    } ext_state_e;

    typedef struct packed {
        logic            op2sel;
        logic            ad1selc;
        logic            wen1;
        logic            pcwrite;
        logic            memldr;
        logic            memstr;
        logic [2:0]      a;
        logic [2:0]      b;
        logic [2:0]      c;
        logic [2:0]      aluopc;
        logic [3:0]      scnt;
        logic [1:0]      shiftopc;
        logic [DP_W-1:0] imms8;
        logic [DP_W-1:0] imms5;
    } dp_ctrl_t;

endpackage

// File: rtl/dp_decode_core.sv
// Combinational instruction decoder for the decode stage.
// Produces the control bundle, fusing a pending EXT payload into immediates.
module dp_decode_core
    import dp_pkg::*;
#(
    parameter int REG_WIDTH = DP_W
) (
    input  logic [REG_WIDTH-1:0] i_ins,
    input  logic                 i_ext_pending,
    input  logic [7:0]           i_ext_payload,
    output dp_ctrl_t             o_ctrl
);

    logic                 w_alu;
    logic                 w_cmp;
    logic                 w_shift;
    logic                 w_memldr;
    logic                 w_memstr;
    logic                 w_pcwrite;
    logic [REG_WIDTH-1:0] w_sp;
    logic [REG_WIDTH-1:0] w_imm8_plain;
    logic [REG_WIDTH-1:0] w_imm5_plain;
    logic [REG_WIDTH-1:0] w_imm8_fused;
    logic [REG_WIDTH-1:0] w_imm5_fused;
    logic [REG_WIDTH-1:0] w_imm8;
    logic [REG_WIDTH-1:0] w_imm5;

    // Instruction class from the opcode field; every flag set in every arm
    always_comb begin
        w_alu   = 1'b0;
        w_cmp   = 1'b0;
        w_shift = 1'b0;
        unique case (i_ins[14:12])
            OPC_NONE: begin
                w_alu   = 1'b0;
                w_cmp   = 1'b0;
                w_shift = 1'b0;
            end
            OPC_CMP: begin
                w_alu   = 1'b0;
                w_cmp   = 1'b1;
                w_shift = 1'b0;
            end
            OPC_SHIFT: begin
                w_alu   = 1'b0;
                w_cmp   = 1'b0;
                w_shift = 1'b1;
            end
            default: begin
                w_alu   = ~i_ins[15];
                w_cmp   = 1'b0;
                w_shift = 1'b0;
            end
        endcase
    end

    assign w_memldr  = (i_ins[15:13] == 3'd4);
    assign w_memstr  = (i_ins[15:13] == 3'd5);
    assign w_pcwrite = (i_ins[15:8] == PCW_OPC);

    // Plain immediates are sign extended; fused ones shift the payload up
    assign w_sp = {{(REG_WIDTH-8){i_ext_payload[7]}}, i_ext_payload};

    assign w_imm8_plain = {{(REG_WIDTH-8){i_ins[7]}}, i_ins[7:0]};
    assign w_imm5_plain = {{(REG_WIDTH-5){i_ins[4]}}, i_ins[4:0]};

    assign w_imm8_fused = (w_sp << 8)
                        | {{(REG_WIDTH-8){1'b0}}, i_ins[7:0]};
    assign w_imm5_fused = (w_sp << 5)
                        | {{(REG_WIDTH-5){1'b0}}, i_ins[4:0]};

    assign w_imm8 = i_ext_pending ? w_imm8_fused : w_imm8_plain;
    assign w_imm5 = i_ext_pending ? w_imm5_fused : w_imm5_plain;

    // Assemble the control bundle
    always_comb begin
        o_ctrl          = '0;
        o_ctrl.op2sel   = ~(w_shift & ~i_ins[15]) & i_ins[8];
        o_ctrl.ad1selc  = ~(w_alu & ~i_ins[15]) | i_ins[8];
        o_ctrl.wen1     = w_memldr | w_pcwrite
                        | (~w_cmp & ~i_ins[15]);
        o_ctrl.pcwrite  = w_pcwrite;
        o_ctrl.memldr   = w_memldr;
        o_ctrl.memstr   = w_memstr;
        o_ctrl.a        = i_ins[11:9];
        o_ctrl.b        = i_ins[7:5];
        o_ctrl.c        = i_ins[4:2];
        o_ctrl.aluopc   = i_ins[14:12];
        o_ctrl.scnt     = i_ins[3:0];
        o_ctrl.shiftopc = {i_ins[8], i_ins[4]};
        o_ctrl.imms8    = DP_W'(w_imm8);
        o_ctrl.imms5    = DP_W'(w_imm5);
    end

endmodule

// File: rtl/dp_decode_stage.sv
// Registered, handshaked decode stage with EXT-prefix fusion.
// Owns the prefix FSM, the payload register and the output register.
module dp_decode_stage
    import dp_pkg::*;
#(
    parameter int          REG_WIDTH = DP_W,
    parameter int          PC_WIDTH  = 16,
    parameter logic [7:0]  EXT_OPC   = 8'hD0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] in_ins,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output dp_ctrl_t             out_ctrl,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic                 out_ext_used
);

    ext_state_e            r_state;
    ext_state_e            w_state_nxt;
    logic [7:0]            r_payload;
    logic                  r_out_valid;
    dp_ctrl_t              r_out_ctrl;
    logic [PC_WIDTH-1:0]   r_out_pc;
    logic                  r_out_ext;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_is_ext;
    logic                  w_take_ext;
    logic                  w_take_ins;
    logic                  w_pending;
    dp_ctrl_t              w_ctrl;

    assign w_is_ext = (in_ins[15:8] == EXT_OPC);

    dp_decode_core #(
        .REG_WIDTH (REG_WIDTH)
    ) u_core (
        .i_ins         (in_ins),
        .i_ext_pending (w_pending),
        .i_ext_payload (r_payload),
        .o_ctrl        (w_ctrl)
    );

    // Prefix state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EXT_NONE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prefix next state: flush drops it, accepted words decide the rest
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EXT_NONE;
        end else if (w_take_ext) begin
            w_state_nxt = EXT_PEND;
        end else if (w_take_ins) begin
            w_state_nxt = EXT_NONE;
        end
    end

    // Handshake and transfer qualifiers derived from state and ports
    always_comb begin
        w_pending  = (r_state == EXT_PEND);
        w_in_ready = (~r_out_valid | out_ready) & ~flush;
        w_accept   = in_valid & w_in_ready;
        w_take_ext = w_accept & w_is_ext;
        w_take_ins = w_accept & ~w_is_ext;
    end

    // Prefix payload, held until a consuming word arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_payload <= 8'h00;
        end else if (w_take_ext) begin
            r_payload <= in_ins[7:0];
        end
    end

    // Output register; loads only when empty or being drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            r_out_pc    <= '0;
            r_out_ext   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_take_ins) begin
            r_out_valid <= 1'b1;
            r_out_ctrl  <= w_ctrl;
            r_out_pc    <= in_pc;
            r_out_ext   <= w_pending;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_ctrl     = r_out_ctrl;
    assign out_pc       = r_out_pc;
    assign out_ext_used = r_out_ext;

endmodule

// File: tb/tb_dp_decode_stage.sv
// Self-checking bench for dp_decode_stage.
// Vector table plus scoreboard, with hand-written multi-cycle sequences.
module tb_dp_decode_stage;
    import dp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ins;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    dp_ctrl_t    out_ctrl;
    logic [15:0] out_pc;
    logic        out_ext_used;

    typedef struct {
        dp_ctrl_t    ctrl;
        logic [15:0] pc;
        logic        ext;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        dp_ctrl_t    ctrl;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   total;
    int   bad;

    dp_decode_stage #(
        .REG_WIDTH (16),
        .PC_WIDTH  (16),
        .EXT_OPC   (8'hD0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ins       (in_ins),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_pc       (out_pc),
        .out_ext_used (out_ext_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dp_ctrl_t mk(
        input logic op2, input logic ad1, input logic wen,
        input logic pcw, input logic ld, input logic st,
        input logic [2:0] a, input logic [2:0] b,
        input logic [2:0] c, input logic [2:0] opc,
        input logic [3:0] scnt, input logic [1:0] sh,
        input logic [15:0] i8, input logic [15:0] i5);
        dp_ctrl_t r;
        r.op2sel   = op2;
        r.ad1selc  = ad1;
        r.wen1     = wen;
        r.pcwrite  = pcw;
        r.memldr   = ld;
        r.memstr   = st;
        r.a        = a;
        r.b        = b;
        r.c        = c;
        r.aluopc   = opc;
        r.scnt     = scnt;
        r.shiftopc = sh;
        r.imms8    = i8;
        r.imms5    = i5;
        return r;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: compare each output transfer against the queue head
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got pc %h want none",
                         out_pc);
            end else begin
                e = sb.pop_front();
                chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                chk("out_pc", 64'(out_pc), 64'(e.pc));
                chk("out_ext", 64'(out_ext_used), 64'(e.ext));
            end
        end
    end

    task automatic send(input logic [15:0] ins,
                        input logic [15:0] pc,
                        input logic push,
                        input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_ins   = ins;
        in_pc    = pc;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ex(input dp_ctrl_t c,
                                input logic [15:0] pc,
                                input logic ext);
        exp_t e;
        e.ctrl = c;
        e.pc   = pc;
        e.ext  = ext;
        return e;
    endfunction

    initial begin
        exp_t none;
        none = ex('0, 16'h0, 1'b0);
        total = 0;
        bad   = 0;

        vecs[0] = '{16'h1A45, mk(0,0,1,0,0,0,3'd5,3'd2,3'd1,3'd1,
                                 4'h5,2'd0,16'h0045,16'h0005)};
        vecs[1] = '{16'h83F0, mk(1,1,1,0,1,0,3'd1,3'd7,3'd4,3'd0,
                                 4'h0,2'd3,16'hFFF0,16'hFFF0)};
        vecs[2] = '{16'hCE00, mk(0,1,1,1,0,0,3'd7,3'd0,3'd0,3'd4,
                                 4'h0,2'd0,16'h0000,16'h0000)};
        vecs[3] = '{16'h73BC, mk(0,1,1,0,0,0,3'd1,3'd5,3'd7,3'd7,
                                 4'hC,2'd3,16'hFFBC,16'hFFFC)};
        vecs[4] = '{16'h6C2A, mk(0,1,0,0,0,0,3'd6,3'd1,3'd2,3'd6,
                                 4'hA,2'd0,16'h002A,16'h000A)};
        vecs[5] = '{16'hA113, mk(1,1,0,0,0,1,3'd0,3'd0,3'd4,3'd2,
                                 4'h3,2'd3,16'h0013,16'hFFF3)};
        vecs[6] = '{16'h5301, mk(1,1,1,0,0,0,3'd1,3'd0,3'd0,3'd5,
                                 4'h1,2'd2,16'h0001,16'h0001)};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ins    = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_ext", 64'(out_ext_used), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            logic [15:0] pc;
            pc = 16'h0100 + 16'(i);
            send(vecs[i].ins, pc, 1'b1, ex(vecs[i].ctrl, pc, 1'b0));
            chk("latency", 64'(out_valid), 64'd1);
        end
        drain();

        send(16'hD012, 16'h0200, 1'b0, none);
        chk("prefix_no_out", 64'(out_valid), 64'd0);
        send(16'h83F0, 16'h0202, 1'b1,
             ex(mk(1,1,1,0,1,0,3'd1,3'd7,3'd4,3'd0,
                   4'h0,2'd3,16'h12F0,16'h0250), 16'h0202, 1'b1));
        drain();
        chk("fuse_single", 64'(out_valid), 64'd0);

        send(16'hD012, 16'h0300, 1'b0, none);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ins   = 16'h83F0;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        send(16'h83F0, 16'h0302, 1'b1, ex(vecs[1].ctrl, 16'h0302, 1'b0));
        drain();

        out_ready = 1'b0;
        send(16'h1A45, 16'h0400, 1'b1, ex(vecs[0].ctrl, 16'h0400, 1'b0));
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_ctrl", 64'(out_ctrl), 64'(vecs[0].ctrl));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release", 64'(in_ready), 64'd1);
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_sb", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        send(16'hD0AA, 16'h0500, 1'b0, none);
        send(16'hD001, 16'h0501, 1'b0, none);
        chk("dbl_no_out", 64'(out_valid), 64'd0);
        send(16'h83F0, 16'h0502, 1'b1,
             ex(mk(1,1,1,0,1,0,3'd1,3'd7,3'd4,3'd0,
                   4'h0,2'd3,16'h01F0,16'h0030), 16'h0502, 1'b1));
        send(16'hCE00, 16'h0503, 1'b1, ex(vecs[2].ctrl, 16'h0503, 1'b0));
        drain();

        out_ready = 1'b0;
        send(16'h1A45, 16'h0600, 1'b1, ex(vecs[0].ctrl, 16'h0600, 1'b0));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ctrl", 64'(out_ctrl), 64'd0);
        chk("mrst_pc", 64'(out_pc), 64'd0);
        chk("mrst_ext", 64'(out_ext_used), 64'd0);
        sb.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(16'hD012, 16'h0700, 1'b0, none);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h83F0, 16'h0702, 1'b1, ex(vecs[1].ctrl, 16'h0702, 1'b0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
